// File: rtl/fp16_minmax_scan.sv
`default_nettype none
//==============================================================================
// Module      : fp16_minmax_scan
// Description : Streaming fp16 min/max finder; one registered comparator is
//               time-shared between the running max and running min.
//               Optional macro TRUE_NEG_ORDER_EN swaps gt/lt for negative pairs.
// Revision    : 1.0 - initial release
//==============================================================================
module fp16_minmax_scan #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_max,
    output logic [15:0]      out_min,
    output logic [IDX_W-1:0] out_max_idx,
    output logic [IDX_W-1:0] out_min_idx,
    output logic [IDX_W-1:0] out_last_idx,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ACCEPT  = 3'd1,
        S_CMP_MAX = 3'd2,
        S_UPD_MAX = 3'd3,
        S_CMP_MIN = 3'd4,
        S_UPD_MIN = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [IDX_W-1:0] c_IDX_MAX = '1;

    state_t           r_state;
    logic [15:0]      r_cur, r_max, r_min;
    logic [IDX_W-1:0] r_idx, r_max_idx, r_min_idx;
    logic             r_ovf, r_last;
    logic             r_gt, r_lt;
    logic [15:0]      r_out_max, r_out_min;
    logic [IDX_W-1:0] r_out_max_idx, r_out_min_idx, r_out_last_idx;
    logic             r_out_ovf;

    logic [15:0]      w_cmp_y;
    logic             w_gt_raw, w_lt_raw, w_swap, w_gt, w_lt;
    logic [15:0]      w_min_nx;
    logic [IDX_W-1:0] w_min_idx_nx;

    // Comparator operand Y follows the phase; X is always the current operand.
    assign w_cmp_y = (r_state == S_CMP_MIN) ? r_min : r_max;

    always_comb begin
        w_gt_raw = 1'b0;
        w_lt_raw = 1'b0;
        if (r_cur[15] != w_cmp_y[15]) begin
            w_gt_raw = ~r_cur[15];
            w_lt_raw = r_cur[15];
        end else begin
            w_gt_raw = (r_cur[14:0] > w_cmp_y[14:0]);
            w_lt_raw = (r_cur[14:0] < w_cmp_y[14:0]);
        end
    end

`ifdef TRUE_NEG_ORDER_EN
    assign w_swap = r_cur[15] & w_cmp_y[15];
`else
    assign w_swap = 1'b0;
`endif

    assign w_gt = w_swap ? w_lt_raw : w_gt_raw;
    assign w_lt = w_swap ? w_gt_raw : w_lt_raw;

    // Min state as it will be after UPD_MIN, so DONE can publish it directly.
    assign w_min_nx     = r_lt ? r_cur : r_min;
    assign w_min_idx_nx = r_lt ? r_idx : r_min_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cur          <= '0;
            r_max          <= '0;
            r_min          <= '0;
            r_idx          <= '0;
            r_max_idx      <= '0;
            r_min_idx      <= '0;
            r_ovf          <= 1'b0;
            r_last         <= 1'b0;
            r_gt           <= 1'b0;
            r_lt           <= 1'b0;
            r_out_max      <= '0;
            r_out_min      <= '0;
            r_out_max_idx  <= '0;
            r_out_min_idx  <= '0;
            r_out_last_idx <= '0;
            r_out_ovf      <= 1'b0;
        end else begin
            r_gt <= w_gt;
            r_lt <= w_lt;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_cur     <= in_data;
                        r_max     <= in_data;
                        r_min     <= in_data;
                        r_idx     <= '0;
                        r_max_idx <= '0;
                        r_min_idx <= '0;
                        r_ovf     <= 1'b0;
                        r_last    <= in_last;
                        if (in_last) begin
                            r_out_max      <= in_data;
                            r_out_min      <= in_data;
                            r_out_max_idx  <= '0;
                            r_out_min_idx  <= '0;
                            r_out_last_idx <= '0;
                            r_out_ovf      <= 1'b0;
                            r_state        <= S_DONE;
                        end else begin
                            r_state <= S_ACCEPT;
                        end
                    end
                end
                S_ACCEPT: begin
                    if (in_valid) begin
                        r_cur  <= in_data;
                        r_last <= in_last;
                        if (r_idx == c_IDX_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                        r_state <= S_CMP_MAX;
                    end
                end
                S_CMP_MAX: r_state <= S_UPD_MAX;
                S_UPD_MAX: begin
                    if (r_gt) begin
                        r_max     <= r_cur;
                        r_max_idx <= r_idx;
                    end
                    r_state <= S_CMP_MIN;
                end
                S_CMP_MIN: r_state <= S_UPD_MIN;
                S_UPD_MIN: begin
                    r_min     <= w_min_nx;
                    r_min_idx <= w_min_idx_nx;
                    if (r_last) begin
                        r_out_max      <= r_max;
                        r_out_min      <= w_min_nx;
                        r_out_max_idx  <= r_max_idx;
                        r_out_min_idx  <= w_min_idx_nx;
                        r_out_last_idx <= r_idx;
                        r_out_ovf      <= r_ovf;
                        r_state        <= S_DONE;
                    end else begin
                        r_state <= S_ACCEPT;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready     = ((r_state == S_IDLE) || (r_state == S_ACCEPT)) && !rst;
    assign out_valid    = (r_state == S_DONE);
    assign busy         = (r_state != S_IDLE);
    assign out_max      = r_out_max;
    assign out_min      = r_out_min;
    assign out_max_idx  = r_out_max_idx;
    assign out_min_idx  = r_out_min_idx;
    assign out_last_idx = r_out_last_idx;
    assign out_ovf      = r_out_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fp16_minmax_scan.sv
`default_nettype none
//==============================================================================
// Module      : tb_fp16_minmax_scan
// Description : Self-checking bench for fp16_minmax_scan (IDX_W=8 and IDX_W=2
//               instances driven in lockstep); honours TRUE_NEG_ORDER_EN.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fp16_minmax_scan;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_last, out_ready;
    logic [15:0] in_data;

    logic        in_ready8, out_valid8, ovf8, busy8;
    logic [15:0] max8, min8;
    logic [7:0]  maxi8, mini8, lasti8;
    logic        in_ready2, out_valid2, ovf2, busy2;
    logic [15:0] max2, min2;
    logic [1:0]  maxi2, mini2, lasti2;

    always #5 clk = ~clk;

    fp16_minmax_scan #(.IDX_W(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid8),
        .out_ready(out_ready), .out_max(max8), .out_min(min8),
        .out_max_idx(maxi8), .out_min_idx(mini8), .out_last_idx(lasti8),
        .out_ovf(ovf8), .busy(busy8)
    );

    fp16_minmax_scan #(.IDX_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid2),
        .out_ready(out_ready), .out_max(max2), .out_min(min2),
        .out_max_idx(maxi2), .out_min_idx(mini2), .out_last_idx(lasti2),
        .out_ovf(ovf2), .busy(busy2)
    );

    typedef struct {
        logic [15:0] mx;
        logic [15:0] mn;
        int          mxi;
        int          mni;
        int          li;
        logic        ovf;
    } res_t;

    typedef struct {
        int          n;
        logic [15:0] d [6];
        res_t        e;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          hs_cyc   = 0;
    logic [15:0] burst_q [$];
    vec_t        tbl [6];
    logic [15:0] pool [8];

    always @(posedge clk) cyc <= cyc + 1;

    // Total order as a plain integer rank: larger rank = greater operand.
    function automatic int rank(input logic [15:0] x);
        int mag;
        mag = int'({17'd0, x[14:0]});
`ifdef TRUE_NEG_ORDER_EN
        return x[15] ? (32767 - mag) : (32768 + mag);
`else
        return x[15] ? mag : (32768 + mag);
`endif
    endfunction

    function automatic res_t model(input int w);
        res_t r;
        int   lim;
        int   n;
        lim   = (1 << w) - 1;
        n     = burst_q.size();
        r.mx  = burst_q[0];
        r.mn  = burst_q[0];
        r.mxi = 0;
        r.mni = 0;
        for (int i = 1; i < n; i++) begin
            if (rank(burst_q[i]) > rank(r.mx)) begin
                r.mx  = burst_q[i];
                r.mxi = (i > lim) ? lim : i;
            end
            if (rank(burst_q[i]) < rank(r.mn)) begin
                r.mn  = burst_q[i];
                r.mni = (i > lim) ? lim : i;
            end
        end
        r.li  = (n - 1 > lim) ? lim : n - 1;
        r.ovf = (n > lim + 1);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_res8(input string tag, input res_t e);
        chk({tag, ".max8"},   {16'd0, max8},   {16'd0, e.mx});
        chk({tag, ".min8"},   {16'd0, min8},   {16'd0, e.mn});
        chk({tag, ".maxi8"},  {24'd0, maxi8},  e.mxi);
        chk({tag, ".mini8"},  {24'd0, mini8},  e.mni);
        chk({tag, ".lasti8"}, {24'd0, lasti8}, e.li);
        chk({tag, ".ovf8"},   {31'd0, ovf8},   {31'd0, e.ovf});
    endtask

    task automatic chk_res2(input string tag, input res_t e);
        chk({tag, ".max2"},   {16'd0, max2},   {16'd0, e.mx});
        chk({tag, ".min2"},   {16'd0, min2},   {16'd0, e.mn});
        chk({tag, ".maxi2"},  {30'd0, maxi2},  e.mxi);
        chk({tag, ".mini2"},  {30'd0, mini2},  e.mni);
        chk({tag, ".lasti2"}, {30'd0, lasti2}, e.li);
        chk({tag, ".ovf2"},   {31'd0, ovf2},   {31'd0, e.ovf});
    endtask

    // Called at a falling edge; junk is driven while in_ready is low.
    task automatic put(input logic [15:0] d, input logic l);
        int k;
        k = 0;
        while (!in_ready8 && k < 64) begin
            in_valid = 1'($urandom % 2);
            in_data  = 16'($urandom);
            in_last  = 1'($urandom % 2);
            @(negedge clk);
            k++;
        end
        if (k >= 64) chk("put.in_ready", {31'd0, in_ready8}, 32'd1);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        hs_cyc   = cyc;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic finish_burst(input string tag, input res_t e8, input int hold);
        int k;
        k = 0;
        while (!out_valid8 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".out_valid"}, {31'd0, out_valid8}, 32'd1);
        chk({tag, ".latency"}, cyc - hs_cyc + 1, (burst_q.size() == 1) ? 1 : 5);
        chk_res8(tag, e8);
        chk_res2(tag, model(2));
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'($urandom % 2);
            in_data  = 16'($urandom);
            in_last  = 1'($urandom % 2);
            @(negedge clk);
            chk({tag, ".hold.in_ready"}, {31'd0, in_ready8}, 32'd0);
            chk({tag, ".hold.out_valid"}, {31'd0, out_valid8}, 32'd1);
            chk_res8({tag, ".hold"}, e8);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".post.out_valid"}, {31'd0, out_valid8}, 32'd0);
        chk({tag, ".post.busy"},      {31'd0, busy8},      32'd0);
        chk({tag, ".post.in_ready"},  {31'd0, in_ready8},  32'd1);
        chk({tag, ".post.max8"},      {16'd0, max8},       {16'd0, e8.mx});
    endtask

    task automatic run(input string tag, input res_t e8, input int hold, input bit gaps);
        for (int i = 0; i < burst_q.size(); i++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                repeat ($urandom % 3) @(negedge clk);
            end
            put(burst_q[i], (i == burst_q.size() - 1));
        end
        finish_burst(tag, e8, hold);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".max8"},      {16'd0, max8},       32'd0);
        chk({tag, ".min8"},      {16'd0, min8},       32'd0);
        chk({tag, ".maxi8"},     {24'd0, maxi8},      32'd0);
        chk({tag, ".mini8"},     {24'd0, mini8},      32'd0);
        chk({tag, ".lasti8"},    {24'd0, lasti8},     32'd0);
        chk({tag, ".ovf8"},      {31'd0, ovf8},       32'd0);
        chk({tag, ".out_valid"}, {31'd0, out_valid8}, 32'd0);
        chk({tag, ".busy"},      {31'd0, busy8},      32'd0);
        chk({tag, ".max2"},      {16'd0, max2},       32'd0);
        chk({tag, ".lasti2"},    {30'd0, lasti2},     32'd0);
    endtask

    initial begin
        res_t e;
        int   n;

        tbl[0].n = 3; tbl[0].d = '{16'h3C00, 16'h4000, 16'h3800, 16'h0, 16'h0, 16'h0};
        tbl[0].e = '{16'h4000, 16'h3800, 1, 2, 2, 1'b0};
        tbl[1].n = 1; tbl[1].d = '{16'hBC00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        tbl[1].e = '{16'hBC00, 16'hBC00, 0, 0, 0, 1'b0};
        tbl[2].n = 2; tbl[2].d = '{16'hBC00, 16'hC000, 16'h0, 16'h0, 16'h0, 16'h0};
`ifdef TRUE_NEG_ORDER_EN
        tbl[2].e = '{16'hBC00, 16'hC000, 0, 1, 1, 1'b0};
`else
        tbl[2].e = '{16'hC000, 16'hBC00, 1, 0, 1, 1'b0};
`endif
        tbl[3].n = 3; tbl[3].d = '{16'h0000, 16'h8000, 16'h0000, 16'h0, 16'h0, 16'h0};
        tbl[3].e = '{16'h0000, 16'h8000, 0, 1, 2, 1'b0};
        tbl[4].n = 3; tbl[4].d = '{16'h7C00, 16'h7E00, 16'hFC00, 16'h0, 16'h0, 16'h0};
        tbl[4].e = '{16'h7E00, 16'hFC00, 1, 2, 2, 1'b0};
        tbl[5].n = 5; tbl[5].d = '{16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0};
        tbl[5].e = '{16'h1234, 16'h1234, 0, 0, 4, 1'b0};

        pool = '{16'h0000, 16'h8000, 16'h3C00, 16'hBC00, 16'h4000, 16'hC000, 16'h7C00, 16'h0001};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.in_ready", {31'd0, in_ready8}, 32'd0);
        chk_zero("reset");
        rst = 1'b0;
        #1;
        chk("reset.release.in_ready", {31'd0, in_ready8}, 32'd1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            burst_q.delete();
            for (int j = 0; j < tbl[i].n; j++) burst_q.push_back(tbl[i].d[j]);
            run($sformatf("vec%0d", i), tbl[i].e, (i == 0) ? 10 : 0, 1'b0);
        end

        // Reset in the middle of a burst, while a compare is in flight.
        burst_q = '{16'h4500, 16'h4600};
        put(16'h4500, 1'b0);
        put(16'h4600, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst.in_ready", {31'd0, in_ready8}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_zero("midrst");
        @(negedge clk);
        burst_q = '{16'h4500, 16'h3000, 16'h4600};
        run("after_rst", model(8), 0, 1'b0);

        // Six operands overflow the 2-bit index instance.
        burst_q = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0009, 16'h0000};
        e = '{16'h0009, 16'h0000, 4, 5, 5, 1'b0};
        run("ovf", e, 0, 1'b0);
        chk("ovf.ovf2",   {31'd0, ovf2},   32'd1);
        chk("ovf.lasti2", {30'd0, lasti2}, 32'd3);
        chk("ovf.maxi2",  {30'd0, maxi2},  32'd3);
        chk("ovf.mini2",  {30'd0, mini2},  32'd3);

        for (int r = 0; r < 40; r++) begin
            burst_q.delete();
            n = (r == 39) ? 260 : 1 + int'($urandom % 12);
            for (int j = 0; j < n; j++) begin
                if ($urandom % 3 == 0) burst_q.push_back(pool[$urandom % 8]);
                else                   burst_q.push_back(16'($urandom));
            end
            run($sformatf("rnd%0d", r), model(8), int'($urandom % 3), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
